// File: rtl/regfile_ctl.sv
// regfile_ctl: captures a 64-bit snapshot and streams it LSB byte first; REGFILE_CTL_CHECKSUM_EN appends an XOR checksum byte
module regfile_ctl #(
  parameter int IDLE_GAP = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cap_valid_i,
  input  logic [63:0] cap_data_i,
  output logic        cap_ready_o,
  output logic        reg_wr_en_o,
  output logic [63:0] reg_wr_data_o,
  output logic [2:0]  reg_rd_addr_o,
  input  logic [7:0]  reg_rd_data_i,
  output logic        out_valid_o,
  output logic [7:0]  out_data_o,
  output logic        out_last_o,
  input  logic        out_ready_i,
  output logic        busy_o
);
`ifdef REGFILE_CTL_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`endif
  state_t state, next, done;
  logic [2:0] cnt;
  logic [7:0] gap;
  logic cap_hs, out_hs;
  assign cap_hs = cap_valid_i & cap_ready_o;
  assign out_hs = out_valid_o & out_ready_i;
  assign done = (IDLE_GAP == 0) ? IDLE : GAP;
  assign reg_wr_en_o = cap_hs;
  assign reg_wr_data_o = cap_data_i;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = cap_hs ? SEND : IDLE;
`ifdef REGFILE_CTL_CHECKSUM_EN
      SEND: next = (out_hs && cnt == 3'd7) ? CSUM : SEND;
      CSUM: next = out_hs ? done : CSUM;
`else
      SEND: next = (out_hs && cnt == 3'd7) ? done : SEND;
`endif
      GAP: next = (gap == 8'(IDLE_GAP - 1)) ? IDLE : GAP;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      cnt <= 3'd0;
      gap <= 8'd0;
    end else begin
      cnt <= cap_hs ? 3'd0 : (state == SEND && out_hs) ? cnt + 3'd1 : cnt;
      gap <= (state == GAP) ? gap + 8'd1 : 8'd0;
    end
`ifdef REGFILE_CTL_CHECKSUM_EN
  logic [7:0] acc;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) acc <= 8'd0;
    else acc <= cap_hs ? 8'd0 : (state == SEND && out_hs) ? acc ^ out_data_o : acc;
`endif
  always_comb begin
    cap_ready_o = state == IDLE;
    busy_o = state != IDLE;
    reg_rd_addr_o = (state == SEND) ? cnt : 3'd0;
`ifdef REGFILE_CTL_CHECKSUM_EN
    out_valid_o = state == SEND || state == CSUM;
    out_data_o = (state == SEND) ? reg_rd_data_i : (state == CSUM) ? acc : 8'd0;
    out_last_o = state == CSUM;
`else
    out_valid_o = state == SEND;
    out_data_o = (state == SEND) ? reg_rd_data_i : 8'd0;
    out_last_o = state == SEND && cnt == 3'd7;
`endif
  end
endmodule

// File: tb/tb_regfile_ctl.sv
// tb_regfile_ctl: directed-vector bench for regfile_ctl with a behavioural 8-byte register file
module tb_regfile_ctl;
`ifdef REGFILE_CTL_CHECKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int GAP = 3;
  logic clk = 0, rst_n = 0, cap_valid = 0, out_ready = 1;
  logic cap_ready, wr_en, out_valid, out_last, busy;
  logic [63:0] cap_data = 0, wr_data, rf = 0;
  logic [2:0] rd_addr;
  logic [7:0] rd_data, out_data;
  int cyc = 0, compared = 0, mismatched = 0;
  int cap_cyc, first_hs, last_hs, got_n, unstable;
  logic [7:0] got[16];
  logic got_last[16];
  logic [2:0] got_addr[16];

  regfile_ctl #(.IDLE_GAP(GAP)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cap_valid_i(cap_valid), .cap_data_i(cap_data),
    .cap_ready_o(cap_ready), .reg_wr_en_o(wr_en), .reg_wr_data_o(wr_data),
    .reg_rd_addr_o(rd_addr), .reg_rd_data_i(rd_data), .out_valid_o(out_valid),
    .out_data_o(out_data), .out_last_o(out_last), .out_ready_i(out_ready), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (wr_en) rf <= wr_data;
  assign rd_data = rf[{rd_addr, 3'b000} +: 8];

  function automatic logic [7:0] exp_byte(input logic [63:0] d, input int i);
    logic [7:0] x;
    x = 8'h00;
    if (i < 8) return d[8*i +: 8];
    for (int k = 0; k < 8; k++) x = x ^ d[8*k +: 8];
    return x;
  endfunction

  task automatic capture(input logic [63:0] d);
    cap_data = d;
    cap_valid = 1;
    cap_cyc = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (cap_ready) begin
        cap_cyc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1 cap_valid = 0;
  endtask

  task automatic collect(input bit toggle, input int want, input int budget);
    logic [7:0] pd;
    logic pl;
    logic [2:0] pa;
    bit stalled;
    stalled = 0; pd = 0; pl = 0; pa = 0;
    got_n = 0; unstable = 0; first_hs = -1; last_hs = -1;
    for (int i = 0; i < 16; i++) begin
      got[i] = 'x; got_last[i] = 1'bx; got_addr[i] = 'x;
    end
    out_ready = 1;
    for (int c = 0; c < budget && got_n < want; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (stalled && (out_data !== pd || out_last !== pl || rd_addr !== pa)) unstable++;
        stalled = !out_ready; pd = out_data; pl = out_last; pa = rd_addr;
        if (out_ready) begin
          got[got_n] = out_data; got_last[got_n] = out_last; got_addr[got_n] = rd_addr;
          if (got_n == 0) first_hs = cyc;
          last_hs = cyc;
          got_n++;
        end
      end
      @(posedge clk);
      #1 if (toggle) out_ready = ~out_ready;
    end
    out_ready = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    compared++;
    if (cap_ready !== 1 || busy !== 0 || out_valid !== 0 || out_data !== 0 || out_last !== 0 || rd_addr !== 0 || wr_en !== 0) begin
      mismatched++;
      $display("FAIL reset_outputs: got rdy=%b busy=%b v=%b d=%h l=%b a=%0d we=%b, want 1 0 0 00 0 0 0", cap_ready, busy, out_valid, out_data, out_last, rd_addr, wr_en);
    end
    cap_valid = 1;
    #1 compared++;
    if (wr_en !== 1) begin
      mismatched++;
      $display("FAIL reset_wr_en_follows_valid: got %b want 1", wr_en);
    end
    cap_valid = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_stream();
    logic [63:0] d = 64'h0807_0605_0403_0201;
    capture(d);
    collect(0, NB, 40);
    compared++;
    if (got_n !== NB || first_hs !== cap_cyc + 1 || last_hs !== cap_cyc + NB) begin
      mismatched++;
      $display("FAIL stream_timing: got n=%0d first=%0d last=%0d, want n=%0d first=%0d last=%0d", got_n, first_hs, last_hs, NB, cap_cyc + 1, cap_cyc + NB);
    end
    for (int i = 0; i < NB; i++) begin
      compared++;
      if (got[i] !== exp_byte(d, i) || got_last[i] !== (i == NB - 1) || got_addr[i] !== 3'(i < 8 ? i : 0)) begin
        mismatched++;
        $display("FAIL stream_byte%0d: got %h last=%b addr=%0d, want %h last=%b addr=%0d", i, got[i], got_last[i], got_addr[i], exp_byte(d, i), i == NB - 1, i < 8 ? i : 0);
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] d = 64'h0807_0605_0403_0201;
    capture(d);
    collect(1, NB, 80);
    compared++;
    if (got_n !== NB || unstable !== 0) begin
      mismatched++;
      $display("FAIL stall_count_stable: got n=%0d unstable=%0d, want n=%0d unstable=0", got_n, unstable, NB);
    end
    for (int i = 0; i < NB; i++) begin
      compared++;
      if (got[i] !== exp_byte(d, i) || got_last[i] !== (i == NB - 1)) begin
        mismatched++;
        $display("FAIL stall_byte%0d: got %h last=%b, want %h last=%b", i, got[i], got_last[i], exp_byte(d, i), i == NB - 1);
      end
    end
    @(negedge clk);
    compared++;
    if (out_valid !== 0) begin
      mismatched++;
      $display("FAIL stall_no_extra_byte: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_gap();
    capture(64'h1111_2222_3333_4444);
    collect(0, NB, 40);
    for (int k = 1; k <= GAP + 1; k++) begin
      @(negedge clk);
      compared++;
      if (busy !== (k <= GAP) || cap_ready !== (k > GAP) || cyc !== last_hs + k) begin
        mismatched++;
        $display("FAIL gap_cycle%0d: got busy=%b rdy=%b cyc=%0d, want busy=%b rdy=%b cyc=%0d", k, busy, cap_ready, cyc, k <= GAP, k > GAP, last_hs + k);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d1 = 64'h0807_0605_0403_0201, d2 = 64'hFFEE_DDCC_BBAA_9988;
    int viol = 0, acc2 = -1, l1;
    capture(d1);
    cap_data = d2;
    cap_valid = 1;
    fork
      collect(0, NB, 40);
      begin
        for (int c = 0; c < 60; c++) begin
          @(negedge clk);
          if (cap_ready) begin
            acc2 = cyc;
            break;
          end
          if (wr_en || !busy) viol++;
        end
        @(posedge clk);
        #1 cap_valid = 0;
      end
    join
    l1 = last_hs;
    compared++;
    if (viol !== 0 || acc2 !== l1 + GAP + 1) begin
      mismatched++;
      $display("FAIL b2b_hold: got viol=%0d accept=%0d, want viol=0 accept=%0d", viol, acc2, l1 + GAP + 1);
    end
    collect(0, NB, 40);
    compared++;
    if (got_n !== NB || first_hs !== acc2 + 1) begin
      mismatched++;
      $display("FAIL b2b_second_start: got n=%0d first=%0d, want n=%0d first=%0d", got_n, first_hs, NB, acc2 + 1);
    end
    for (int i = 0; i < NB; i++) begin
      compared++;
      if (got[i] !== exp_byte(d2, i) || got_last[i] !== (i == NB - 1)) begin
        mismatched++;
        $display("FAIL b2b_byte%0d: got %h last=%b, want %h last=%b", i, got[i], got_last[i], exp_byte(d2, i), i == NB - 1);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] d = 64'hA5A5_0F0F_F0F0_5A5A;
    capture(64'h1122_3344_5566_7788);
    collect(0, 4, 40);
    #2 rst_n = 0;
    #1 compared++;
    if (out_valid !== 0 || cap_ready !== 1 || busy !== 0 || rd_addr !== 0 || out_data !== 0) begin
      mismatched++;
      $display("FAIL async_reset: got v=%b rdy=%b busy=%b a=%0d d=%h, want 0 1 0 0 00", out_valid, cap_ready, busy, rd_addr, out_data);
    end
    @(negedge clk);
    rst_n = 1;
    capture(d);
    collect(0, NB, 40);
    compared++;
    if (got_n !== NB || first_hs !== cap_cyc + 1) begin
      mismatched++;
      $display("FAIL restart_timing: got n=%0d first=%0d, want n=%0d first=%0d", got_n, first_hs, NB, cap_cyc + 1);
    end
    for (int i = 0; i < NB; i++) begin
      compared++;
      if (got[i] !== exp_byte(d, i) || got_addr[i] !== 3'(i < 8 ? i : 0) || got_last[i] !== (i == NB - 1)) begin
        mismatched++;
        $display("FAIL restart_byte%0d: got %h addr=%0d last=%b, want %h addr=%0d last=%b", i, got[i], got_addr[i], got_last[i], exp_byte(d, i), i < 8 ? i : 0, i == NB - 1);
      end
    end
  endtask

  task automatic test_zero();
    capture(64'h0);
    collect(0, NB, 40);
    compared++;
    if (got_n !== NB) begin
      mismatched++;
      $display("FAIL zero_count: got %0d want %0d", got_n, NB);
    end
    for (int i = 0; i < NB; i++) begin
      compared++;
      if (got[i] !== 8'h00 || got_last[i] !== (i == NB - 1)) begin
        mismatched++;
        $display("FAIL zero_byte%0d: got %h last=%b, want 00 last=%b", i, got[i], got_last[i], i == NB - 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_gap();
    test_back_to_back();
    test_async_reset();
    test_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end
endmodule
